prism_sp_tx_queue_scheduler: RTL and testbench

Frame-atomic round-robin scheduler that shares the single TX DMA read stage between NUM_QUEUES TX descriptor queues. It sits between the per-queue cookie FIFOs, which hold `dma_tx_cookie_t`, and the one cookie FIFO feeding the TX DMA read stage. It grants one queue at a time and forwards that queue's cookies until one with `eof` set has passed, so fragments of different frames never interleave. It also exports per-queue forwarded-frame counters.

---
 rtl/prism_sp_pkg.sv | 11 +
 rtl/prism_sp_tx_queue_scheduler_if.sv | 17 +
 rtl/prism_sp_rr_arbiter.sv | 25 ++
 rtl/prism_sp_tx_queue_scheduler.sv | 62 ++++++
 tb/tb_prism_sp_tx_queue_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prism_sp_pkg.sv
// prism_sp_pkg: shared DMA cookie type, TX scheduler limits and FSM state encoding.
package prism_sp_pkg;
  localparam int TX_SCHED_MAX_QUEUES = 8;
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        sof;
    logic        eof;
  } dma_tx_cookie_t;
  typedef enum logic [1:0] {TXS_IDLE, TXS_FORWARD, TXS_SETTLE} tx_sched_state_t;
endpackage

// File: rtl/prism_sp_tx_queue_scheduler_if.sv
// prism_sp_tx_queue_scheduler_if: per-queue cookie FIFO read ports plus the downstream cookie FIFO write port.
interface prism_sp_tx_queue_scheduler_if #(parameter int NUM_QUEUES = 4);
  logic [NUM_QUEUES-1:0]                               q_empty;
  prism_sp_pkg::dma_tx_cookie_t [NUM_QUEUES-1:0]       q_rd_data;
  logic [NUM_QUEUES-1:0]                               q_rd_en;
  logic                                                o_cookie_fifo_w_full;
  logic                                                o_cookie_fifo_w_wr_en;
  prism_sp_pkg::dma_tx_cookie_t                        o_cookie_fifo_w_wr_data;
  modport master (
    input  q_empty, q_rd_data, o_cookie_fifo_w_full,
    output q_rd_en, o_cookie_fifo_w_wr_en, o_cookie_fifo_w_wr_data
  );
  modport slave (
    output q_empty, q_rd_data, o_cookie_fifo_w_full,
    input  q_rd_en, o_cookie_fifo_w_wr_en, o_cookie_fifo_w_wr_data
  );
endinterface

// File: rtl/prism_sp_rr_arbiter.sv
// prism_sp_rr_arbiter: combinational round-robin pick of the first request above the last grant, wrapping.
module prism_sp_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);
  logic [IDX_W-1:0] idx;
  // Scan from farthest to nearest so the nearest requester above last wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prism_sp_tx_queue_scheduler.sv
// prism_sp_tx_queue_scheduler: frame-atomic round-robin sharing of the TX DMA cookie FIFO between queues.
module prism_sp_tx_queue_scheduler
  import prism_sp_pkg::*;
#(
  parameter  int NUM_QUEUES        = 4,
  parameter  int FRAME_COUNT_WIDTH = 16,
  localparam int IDX_W             = $clog2(NUM_QUEUES)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  prism_sp_tx_queue_scheduler_if.master                 bus,
  input  logic [NUM_QUEUES-1:0]                         queue_enable,
  output logic [NUM_QUEUES-1:0][FRAME_COUNT_WIDTH-1:0]  frame_count,
  output logic                                          active,
  output logic [IDX_W-1:0]                              grant_idx
);
  tx_sched_state_t  state, state_nxt;
  logic [IDX_W-1:0] last_grant, arb_grant;
  logic             arb_valid, fire;
  dma_tx_cookie_t   head;

  prism_sp_rr_arbiter #(.NUM_REQ(NUM_QUEUES)) u_arb (
    .req   (~bus.q_empty & queue_enable),
    .last  (last_grant),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign head   = bus.q_rd_data[grant_idx];
  assign fire   = state == TXS_FORWARD && !bus.q_empty[grant_idx] && !bus.o_cookie_fifo_w_full;
  assign active = state != TXS_IDLE;

  // The granted queue is held until its eof cookie passes, whatever its FIFO or enable does.
  always_comb begin
    state_nxt = state;
    state_nxt = state == TXS_IDLE   ? (arb_valid ? TXS_FORWARD : TXS_IDLE) :
                state == TXS_SETTLE ? TXS_FORWARD :
                fire                ? (head.eof ? TXS_IDLE : TXS_SETTLE) : TXS_FORWARD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                       <= TXS_IDLE;
      grant_idx                   <= '0;
      last_grant                  <= IDX_W'(NUM_QUEUES - 1);
      frame_count                 <= '0;
      bus.q_rd_en                 <= '0;
      bus.o_cookie_fifo_w_wr_en   <= 1'b0;
      bus.o_cookie_fifo_w_wr_data <= '0;
    end else begin
      state                     <= state_nxt;
      bus.q_rd_en               <= fire ? NUM_QUEUES'(1) << grant_idx : '0;
      bus.o_cookie_fifo_w_wr_en <= fire;
      if (state == TXS_IDLE && arb_valid) begin
        grant_idx  <= arb_grant;
        last_grant <= arb_grant;
      end
      if (fire) bus.o_cookie_fifo_w_wr_data <= head;
      if (fire && head.eof) frame_count[grant_idx] <= frame_count[grant_idx] + 1'b1;
    end
  end
endmodule

// File: tb/tb_prism_sp_tx_queue_scheduler.sv
// tb_prism_sp_tx_queue_scheduler: directed and randomized checks against a frame-level round-robin model.
module tb_prism_sp_tx_queue_scheduler;
  import prism_sp_pkg::*;
  localparam int NQ  = 4;
  localparam int FCW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NQ-1:0] queue_enable = '1;
  logic [NQ-1:0][FCW-1:0] frame_count;
  logic active;
  logic [1:0] grant_idx;

  prism_sp_tx_queue_scheduler_if #(.NUM_QUEUES(NQ)) bus ();

  prism_sp_tx_queue_scheduler #(.NUM_QUEUES(NQ), .FRAME_COUNT_WIDTH(FCW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.master),
    .queue_enable (queue_enable),
    .frame_count  (frame_count),
    .active       (active),
    .grant_idx    (grant_idx)
  );

  always #5 clock = ~clock;

  int total = 0, passed = 0, failed = 0, fseq = 0;
  bit full_rand = 0, full_force = 0;
  dma_tx_cookie_t qd[NQ][$];
  dma_tx_cookie_t mf[NQ][$];
  dma_tx_cookie_t got[$], exp_q[$], held[$];
  int m_last = NQ - 1;
  logic [NQ-1:0][FCW-1:0] m_fc = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_q();
    for (int i = 0; i < NQ; i++) begin
      bus.q_empty[i]   = (qd[i].size() == 0);
      bus.q_rd_data[i] = qd[i].size() > 0 ? qd[i][0] : '0;
    end
  endtask

  // One clock: model FIFO pops, capture writes, check strobe pairing and full handling.
  task automatic tick();
    logic pf;
    logic [NQ-1:0] exp_rd;
    dma_tx_cookie_t wd;
    pf = bus.o_cookie_fifo_w_full;
    @(posedge clock);
    #1;
    wd = bus.o_cookie_fifo_w_wr_data;
    exp_rd = bus.o_cookie_fifo_w_wr_en ? NQ'(1) << wd.addr[31:24] : '0;
    if (bus.o_cookie_fifo_w_wr_en === 1'b1) begin
      got.push_back(wd);
      check("write_while_full", 64'(pf), 64'(0));
    end
    if (bus.q_rd_en !== '0 || bus.o_cookie_fifo_w_wr_en !== 1'b0)
      check("rd_en_pairing", 64'(bus.q_rd_en), 64'(exp_rd));
    for (int i = 0; i < NQ; i++)
      if (bus.q_rd_en[i] === 1'b1 && qd[i].size() > 0) void'(qd[i].pop_front());
    drive_q();
    bus.o_cookie_fifo_w_full = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
  endtask

  task automatic add_frame(int q, int nc);
    for (int i = 0; i < nc; i++) begin
      dma_tx_cookie_t c;
      c.addr = {8'(q), 8'(fseq), 16'(i)};
      c.len  = 16'($urandom);
      c.sof  = (i == 0);
      c.eof  = (i == nc - 1);
      qd[q].push_back(c);
      mf[q].push_back(c);
    end
    fseq++;
  endtask

  // Frame-level reference: whole frames in round-robin order over eligible queues.
  task automatic predict(logic [NQ-1:0] mask, int max_frames);
    for (int f = 0; f < max_frames; f++) begin
      int nxt;
      dma_tx_cookie_t ck;
      nxt = -1;
      for (int k = 1; k <= NQ; k++)
        if (nxt < 0 && mask[(m_last + k) % NQ] && mf[(m_last + k) % NQ].size() > 0) nxt = (m_last + k) % NQ;
      if (nxt < 0) break;
      m_last = nxt;
      do begin
        ck = mf[nxt].pop_front();
        exp_q.push_back(ck);
      end while (!ck.eof);
      m_fc[nxt] = m_fc[nxt] + 1'b1;
    end
  endtask

  task automatic run(string tag, int budget);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) check({tag, "_data"}, 64'(got[i]), 64'(exp_q[i]));
    check({tag, "_frame_count"}, 64'(frame_count), 64'(m_fc));
    got.delete();
    exp_q.delete();
  endtask

  task automatic wait_writes(int n, int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_writes", 64'(got.size()), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    full_rand = 0;
    full_force = 0;
    bus.o_cookie_fifo_w_full = 1'b0;
    queue_enable = '1;
    for (int i = 0; i < NQ; i++) begin
      qd[i].delete();
      mf[i].delete();
    end
    drive_q();
    tick();
    reset = 1'b0;
    got.delete();
    exp_q.delete();
    held.delete();
    m_last = NQ - 1;
    m_fc = '0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_wr_en"}, 64'(bus.o_cookie_fifo_w_wr_en), 64'(0));
    check({tag, "_rd_en"}, 64'(bus.q_rd_en), 64'(0));
    check({tag, "_wr_data"}, 64'(bus.o_cookie_fifo_w_wr_data), 64'(0));
    check({tag, "_frame_count"}, 64'(frame_count), 64'(0));
    check({tag, "_active"}, 64'(active), 64'(0));
    check({tag, "_grant_idx"}, 64'(grant_idx), 64'(0));
  endtask

  initial begin
    logic [NQ-1:0] mask;
    do_reset();
    check_reset_outputs("reset");

    // Single 3-cookie frame on q0: writes on ticks 2, 4, 6; idle by tick 7.
    add_frame(0, 3);
    drive_q();
    predict('1, 99);
    for (int t = 1; t <= 7; t++) begin
      tick();
      check("t1_wr_timing", 64'(bus.o_cookie_fifo_w_wr_en), 64'(t == 2 || t == 4 || t == 6));
      if (t == 1) check("t1_grant", 64'(grant_idx), 64'(0));
      if (t == 1) check("t1_active_hi", 64'(active), 64'(1));
      if (t == 7) check("t1_active_lo", 64'(active), 64'(0));
    end
    run("t1", 50);
    check("t1_fc0", 64'(frame_count[0]), 64'(1));

    // q0 and q2 with two 2-cookie frames each alternate frame by frame.
    do_reset();
    add_frame(0, 2); add_frame(0, 2); add_frame(2, 2); add_frame(2, 2);
    drive_q();
    predict('1, 99);
    run("t2", 200);
    check("t2_fc", 64'(frame_count), 64'(16'h0202));

    // Downstream full for 10 cycles mid-frame.
    do_reset();
    add_frame(1, 3);
    drive_q();
    predict('1, 99);
    wait_writes(1, 20);
    full_force = 1;
    bus.o_cookie_fifo_w_full = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("t3_hold_wr", 64'(bus.o_cookie_fifo_w_wr_en), 64'(0));
      check("t3_hold_rd", 64'(bus.q_rd_en), 64'(0));
    end
    full_force = 0;
    bus.o_cookie_fifo_w_full = 1'b0;
    tick();
    check("t3_resume", 64'(bus.o_cookie_fifo_w_wr_en), 64'(1));
    run("t3", 50);

    // Disable q1 after the first cookie of its frame: frame completes, then q1 is skipped.
    do_reset();
    add_frame(1, 4); add_frame(1, 2); add_frame(2, 2);
    drive_q();
    predict(4'b0110, 1);
    predict(4'b0100, 99);
    wait_writes(1, 20);
    queue_enable[1] = 1'b0;
    run("t4", 100);
    check("t4_q1_pending", 64'(bus.q_empty[1]), 64'(0));
    check("t4_idle", 64'(active), 64'(0));

    // Granted q0 runs dry mid-frame while q3 waits.
    do_reset();
    add_frame(0, 3);
    held.push_back(qd[0].pop_back());
    held.push_back(qd[0].pop_back());
    add_frame(3, 2);
    drive_q();
    predict('1, 99);
    wait_writes(1, 20);
    for (int t = 0; t < 5; t++) begin
      tick();
      check("t5_no_switch", 64'(bus.o_cookie_fifo_w_wr_en), 64'(0));
      check("t5_grant", 64'(grant_idx), 64'(0));
    end
    qd[0].push_back(held[1]);
    qd[0].push_back(held[0]);
    drive_q();
    run("t5", 100);

    // 17 single-cookie frames wrap the 4-bit counter to 1.
    do_reset();
    for (int f = 0; f < 17; f++) add_frame(0, 1);
    drive_q();
    predict('1, 99);
    run("t6", 300);
    check("t6_fc_wrap", 64'(frame_count[0]), 64'(1));

    // Reset mid-frame returns every output to its reset value.
    do_reset();
    add_frame(1, 3);
    add_frame(2, 1);
    drive_q();
    wait_writes(1, 20);
    reset = 1'b1;
    tick();
    check_reset_outputs("t7_mid_reset");
    reset = 1'b0;

    // Randomized frames, enable masks and downstream backpressure.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      mask = NQ'($urandom_range(1, (1 << NQ) - 1));
      queue_enable = mask;
      for (int q = 0; q < NQ; q++)
        for (int f = $urandom_range(0, 3); f > 0; f--) add_frame(q, $urandom_range(1, 4));
      drive_q();
      full_rand = 1;
      predict(mask, 99);
      run("rand", 3000);
      check("rand_idle", 64'(active), 64'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
